// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, frame classes, hex display table.
// Frame classification helper counts pressed keys in a 16-bit scan frame.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    FR_EMPTY,
    FR_SINGLE,
    FR_MULTI
  } frame_cls_t;

  typedef struct packed {
    frame_cls_t cls;
    logic [3:0] code;
  } frame_res_t;

  // Index 0 is the rightmost entry; bit order h..a, active-low.
  localparam logic [15:0][7:0] SSEG_HEX = {
    8'b10001110, 8'b10000110, 8'b10100001, 8'b11000110,
    8'b10000011, 8'b10001000, 8'b10010000, 8'b10000000,
    8'b11111000, 8'b10000010, 8'b10010010, 8'b10011001,
    8'b10110000, 8'b10100100, 8'b11111001, 8'b11000000
  };

  function automatic frame_res_t classify(input logic [15:0] frame);
    frame_res_t res;
    logic [4:0] n;
    n        = '0;
    res.code = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n        = n + 5'd1;
        res.code = 4'(i);
      end
    end
    if (n == 5'd0)      res.cls = FR_EMPTY;
    else if (n == 5'd1) res.cls = FR_SINGLE;
    else                res.cls = FR_MULTI;
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Column slot timer: counts 0..SCAN_DIV-1, slot_end high during the terminal count.
// Free-running, no backpressure; slot_end is decoded from the counter (0 cycle latency).
module scan_tick_gen #(
  parameter int SCAN_DIV = 67000
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_end = (cnt_q == LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with frame debounce; key_valid 1 clk after the accepting frame evaluation.
// No backpressure: key_valid/multi_err are single-cycle strobes. KEYPAD_SSEG_EN adds a hex sseg output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 67000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
`ifdef KEYPAD_SSEG_EN
  ,
  output logic [7:0] sseg
`endif
);

  localparam logic [3:0] DB     = 4'(DEBOUNCE_SCANS);
  localparam bit         DB_ONE = (DEBOUNCE_SCANS == 1);

  logic slot_end;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_end (slot_end)
  );

  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  col_out_q, col_out_d;
  logic [15:0] frame_q, frame_d;
  logic        eval_q, eval_d;
  state_t      state_q, state_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;
  logic        multi_err_q, multi_err_d;
  frame_res_t  res;

  always_comb begin
    sync1_d     = row_in;
    sync2_d     = sync1_q;
    col_d       = col_q;
    col_out_d   = col_out_q;
    eval_d      = slot_end && (col_q == 2'd3);
    frame_d     = eval_q ? '0 : frame_q;
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_err_d = 1'b0;
    res         = classify(frame_q);

    // Rows are active-low, so invert to get one "pressed" bit per key.
    if (slot_end) begin
      frame_d[{col_q, 2'b00} +: 4] = ~sync2_q;
      col_d     = col_q + 2'd1;
      col_out_d = {col_out_q[2:0], col_out_q[3]};
    end

    if (eval_q) begin
      multi_err_d = (res.cls == FR_MULTI);
      case (state_q)
        ST_IDLE: begin
          if (res.cls == FR_SINGLE) begin
            cand_d = res.code;
            dcnt_d = 4'd1;
            if (DB_ONE) begin
              state_d     = ST_PRESSED;
              key_code_d  = res.code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (res.cls != FR_SINGLE) begin
            state_d = ST_IDLE;
          end else if (res.code != cand_q) begin
            cand_d = res.code;
            dcnt_d = 4'd1;
          end else begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_d >= DB) begin
              state_d     = ST_PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end
        end
        ST_PRESSED: begin
          if (res.cls == FR_EMPTY) begin
            dcnt_d = 4'd1;
            if (DB_ONE) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (res.cls == FR_EMPTY) begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_d >= DB) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      col_q       <= 2'd0;
      col_out_q   <= 4'b1110;
      frame_q     <= '0;
      eval_q      <= 1'b0;
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      col_q       <= col_d;
      col_out_q   <= col_out_d;
      frame_q     <= frame_d;
      eval_q      <= eval_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;

`ifdef KEYPAD_SSEG_EN
  logic [7:0] sseg_q, sseg_d;

  always_comb sseg_d = SSEG_HEX[key_code_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sseg_q <= 8'b11000000;
    else        sseg_q <= sseg_d;
  end

  assign sseg = sseg_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: physical key-matrix model, frame-level behavioural model, per-cycle compare.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;
`ifdef KEYPAD_SSEG_EN
  logic [7:0] sseg;
`endif

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
`ifdef KEYPAD_SSEG_EN
    ,
    .sseg      (sseg)
`endif
  );

  // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
  logic [15:0] keys = 16'h0000;
  bit          force_en = 1'b1;
  logic [3:0]  force_val = 4'hF;

  always_comb begin
    row_in = 4'hF;
    if (force_en) begin
      row_in = force_val;
    end else begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: each 16-cycle frame sees the key set held at its start; results appear
  // on the cycle after the frame's evaluation cycle.
  logic [15:0] snap;
  bit          held;
  int          run_len, empty_run;
  logic [3:0]  run_code;
  logic [3:0]  exp_code;
  bit          exp_valid, exp_multi;
`ifdef KEYPAD_SSEG_EN
  logic [7:0]  sseg_tab [16] = '{8'b11000000, 8'b11111001, 8'b10100100, 8'b10110000,
                                 8'b10011001, 8'b10010010, 8'b10000010, 8'b11111000,
                                 8'b10000000, 8'b10010000, 8'b10001000, 8'b10000011,
                                 8'b11000110, 8'b10100001, 8'b10000110, 8'b10001110};
  logic [7:0]  exp_sseg;
`endif

  always @(posedge clk or negedge rst_n) begin
    int n;
    logic [3:0] code;
    if (!rst_n) begin
      cyc = 0; snap = '0; held = 0; run_len = 0; empty_run = 0; run_code = '0;
      exp_code = '0; exp_valid = 0; exp_multi = 0;
`ifdef KEYPAD_SSEG_EN
      exp_sseg = 8'b11000000;
`endif
    end else begin
`ifdef KEYPAD_SSEG_EN
      exp_sseg = sseg_tab[exp_code];
`endif
      exp_valid = 0;
      exp_multi = 0;
      if (cyc % FRAME == 1) snap = keys;
      if (cyc > 0 && cyc % FRAME == 0) begin
        n = 0; code = '0;
        for (int i = 0; i < 16; i++) if (snap[i]) begin n++; code = 4'(i); end
        if (n >= 2) exp_multi = 1;
        if (!held) begin
          if (n == 1) begin
            if (run_len > 0 && code == run_code) run_len++;
            else begin run_code = code; run_len = 1; end
            if (run_len >= DB) begin
              held = 1; exp_code = code; exp_valid = 1; run_len = 0; empty_run = 0;
            end
          end else begin
            run_len = 0;
          end
        end else begin
          if (n == 0) begin
            empty_run++;
            if (empty_run >= DB) begin held = 0; empty_run = 0; run_len = 0; end
          end else begin
            empty_run = 0;
          end
        end
      end
      cyc = cyc + 1;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [3:0] exp_col;
    if (cmp_en) begin
      exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
      check("col_out", col_out, exp_col);
      check("key_valid", key_valid, exp_valid);
      check("key_held", key_held, held);
      check("key_code", key_code, exp_code);
      check("multi_err", multi_err, exp_multi);
`ifdef KEYPAD_SSEG_EN
      check("sseg", sseg, exp_sseg);
`endif
    end
  end

  int vcnt = 0, mcnt = 0, last_vcyc = -1;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin vcnt++; last_vcyc = cyc; end
    if (multi_err === 1'b1) mcnt++;
  end

  task automatic wait_frame_start();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((cyc % FRAME) != 0 && k < 3 * FRAME);
    if ((cyc % FRAME) != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL frame_align: cycle %0d, required a multiple of %0d", cyc, FRAME);
    end
    #2;
  endtask

  task automatic frames(input logic [15:0] mask, input int n);
    repeat (n) begin
      wait_frame_start();
      keys = mask;
    end
  endtask

  task automatic settle();
    wait_frame_start();
    keys = '0;
    @(negedge clk);
    @(negedge clk);
    #2;
  endtask

  logic [3:0] walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    @(posedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2 force_val = 4'(i * 5);
      check("rst_col_out", col_out, 4'b1110);
      check("rst_key_code", key_code, 4'd0);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_held", key_held, 1'b0);
    end
    force_en = 1'b0;
    keys = '0;
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("col_walk", col_out, walk[(i / 4) % 4]);
    end

    // Clean press of key 9 (column 2, row 1).
    vcnt = 0;
    frames(16'h0200, 4);
    settle();
    check("press_pulses", vcnt, 1);
    check("press_code", key_code, 4'd9);
    check("press_held", key_held, 1'b1);

    // Release.
    vcnt = 0;
    frames(16'h0000, 2);
    settle();
    check("release_held", key_held, 1'b0);
    check("release_code", key_code, 4'd9);
    check("release_pulses", vcnt, 0);

    // Bounce: a single frame of key 9 must not be accepted.
    vcnt = 0;
    frames(16'h0200, 1);
    frames(16'h0000, 2);
    settle();
    check("bounce_pulses", vcnt, 0);
    check("bounce_held", key_held, 1'b0);

    // Keys 0 and 5 together for three frames.
    vcnt = 0;
    mcnt = 0;
    frames(16'h0021, 3);
    settle();
    check("multi_pulses", mcnt, 3);
    check("multi_valid", vcnt, 0);
    check("multi_held", key_held, 1'b0);

    // Reset in the middle of confirming key 3; key stays pressed through reset.
    frames(16'h0008, 1);
    wait_frame_start();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 vcnt = 0;
    last_vcyc = -1;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    #2;
    check("rstmid_pulses", vcnt, 1);
    check("rstmid_cycle", last_vcyc, 33);
    check("rstmid_code", key_code, 4'd3);
    frames(16'h0000, 3);
    settle();
    check("rstmid_release", key_held, 1'b0);

`ifdef KEYPAD_SSEG_EN
    frames(16'h0400, 3);
    settle();
    check("sseg_code", key_code, 4'd10);
    check("sseg_A", sseg, 8'b10001000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one active-low column at a time and reading back four active-low rows.
- Time-multiplexed like the six-digit seven-segment driver, but in the input direction: column outputs, row inputs.
- Debounces, rejects multi-key presses and produces one key code with a single-cycle valid strobe per press.
- Sits between board keypad pins and user logic, e.g. a digit-entry path that feeds the display driver.

Parameters:
- SCAN_DIV, 67000: clk cycles per column slot; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full frames needed to accept a press or a release; range 1..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  output  4  keypad columns, one-hot active-low; column c is driven when bit c = 0.
- key_code  output  4  last accepted key, code = col*4 + row.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from press acceptance until release acceptance.
- multi_err  output  1  one-cycle pulse per frame in which more than one key is seen.

Behaviour:
- Reset values, asynchronous on rst_n low: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, multi_err=0, state IDLE, all counters and synchronizers 0/idle.
- Synchronization: row_in passes through a 2-FF synchronizer; sampling uses only the synchronized value.
- Slot counter: counts 0..SCAN_DIV-1. On the terminal count:
  - sample the inverted synchronized rows into frame bits [col*4 +: 4];
  - advance the column 0->1->2->3->0 and update col_out in the same cycle.
- A full frame is 4*SCAN_DIV cycles. Frame evaluation happens in the cycle after column 3 is sampled:
  - zero bits set = EMPTY;
  - exactly one bit set = SINGLE(code);
  - two or more bits set = MULTI.
- The frame register clears after evaluation.
- FSM, with a 4-bit debounce counter dcnt and a candidate code cand:
  - IDLE:
    - SINGLE -> cand=code, dcnt=1; go to PRESSED if DEBOUNCE_SCANS==1, else CONFIRM.
    - EMPTY or MULTI -> stay in IDLE.
  - CONFIRM:
    - SINGLE with code==cand -> dcnt+1; when dcnt reaches DEBOUNCE_SCANS go to PRESSED.
    - SINGLE with a different code -> cand=code, dcnt=1.
    - EMPTY or MULTI -> IDLE.
  - Entering PRESSED: key_code<=cand, key_valid=1 for exactly one cycle, key_held=1.
  - PRESSED:
    - EMPTY -> dcnt=1; go to IDLE if DEBOUNCE_SCANS==1, else RELEASE.
    - Any SINGLE or MULTI -> stay in PRESSED; no new key_valid.
  - RELEASE:
    - EMPTY -> dcnt+1; when dcnt reaches DEBOUNCE_SCANS go to IDLE and clear key_held.
    - SINGLE or MULTI -> back to PRESSED; key_held stays 1.
- multi_err pulses one cycle on every MULTI evaluation, in any state.
- Latency: key_valid rises 1 clk after the evaluation that completes debounce. Worst case from a stable press is (DEBOUNCE_SCANS+1) frames + 4 clk.
- key_code holds its value after release. It changes only on a new acceptance.
- Reset asserted mid-operation: everything returns to reset values immediately. A partial debounce is discarded.

Optional Feature:
- Macro KEYPAD_SSEG_EN.
- Defined: adds output sseg[7:0], bit order h..a, active-low, registered. It shows key_code as hex in the team's display encoding:
  - 0=11000000, 1=11111001, 2=10100100, 3=10110000, 4=10011001, 5=10010010, 6=10000010, 7=11111000;
  - 8=10000000, 9=10010000, A=10001000, b=10000011, C=11000110, d=10100001, E=10000110, F=10001110.
  - Reset value 11000000. sseg updates 1 clk after key_code.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package keypad_pkg holds:
  - the FSM state encoding (IDLE, CONFIRM, PRESSED, RELEASE);
  - the 16-entry hex seven-segment constant table;
  - the frame classification encoding (EMPTY, SINGLE, MULTI).
- One sub-module, scan_tick_gen: the SCAN_DIV slot counter that emits a one-cycle slot_end tick.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2; frame = 16 clk):
- Reset: hold rst_n=0 with rows toggling -> col_out=1110, key_code=0, key_valid=0, key_held=0. After release, col_out walks 1110, 1101, 1011, 0111, changing every 4 clk.
- Clean press: row1 low while col_out=1011, for 4 frames -> exactly one key_valid pulse, key_code=9, key_held=1.
- Bounce: key 9 present for 1 frame, then empty -> no key_valid, key_held stays 0.
- Release: after the clean press, 2 empty frames -> key_held=0, key_code stays 9, no pulse.
- Multi-key: keys 0 and 5 held for 3 frames -> multi_err pulses 3 times, no key_valid, state stays IDLE.
- Reset mid-CONFIRM, then press key 3: pulse rst_n after the first frame containing key 3, then keep key 3 pressed -> key_valid arrives only after 2 fresh frames, key_code=3. With KEYPAD_SSEG_EN defined and key 10 pressed: sseg=10001000.
